// File: rtl/paint_scheduler.sv
// -----------------------------------------------------------------------------
// paint_scheduler
//   Owns the single framebuffer write port and serialises two kinds of job onto
//   it: a BRUSH x BRUSH square painted at the cursor, and a full-screen clear.
//   Writes are issued in row-major order over a valid/ready handshake.
//
// Ports
//   clk           system clock, all state on rising edge
//   reset         asynchronous, active-high reset
//   paint_req     request a brush paint (sampled every cycle)
//   cursor_x_pos  brush origin x (top-left corner), sampled when the paint starts
//   cursor_y_pos  brush origin y (top-left corner), sampled when the paint starts
//   paint_color   brush colour, sampled when the paint starts
//   clear_req     request a full-screen clear (sampled every cycle)
//   clear_color   background colour, sampled when the clear starts
//   fb_wr_en      write valid
//   fb_addr       pixel address = y*H_RES + x
//   fb_data       pixel colour
//   fb_wr_ready   framebuffer accepts the write this cycle
//   busy          high while a job is in progress
//   done          one-cycle pulse after the last write of a job is accepted
// -----------------------------------------------------------------------------
module paint_scheduler #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int BRUSH   = 16,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               paint_req,
    input  logic [10:0]        cursor_x_pos,
    input  logic [10:0]        cursor_y_pos,
    input  logic [COLOR_W-1:0] paint_color,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               fb_wr_en,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_wr_ready,
    output logic               busy,
    output logic               done
);

    localparam int CW    = 11;
    localparam int BW    = $clog2(BRUSH + 1);
    localparam int TOTAL = H_RES * V_RES;

    localparam logic [BW-1:0]     D_LAST   = BW'(BRUSH - 1);
    localparam logic [CW-1:0]     X_LAST   = CW'(H_RES - 1);
    localparam logic [CW-1:0]     Y_LAST   = CW'(V_RES - 1);
    localparam logic [CW-1:0]     X_LIMIT  = CW'(H_RES);
    localparam logic [CW-1:0]     Y_LIMIT  = CW'(V_RES);
    localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
    localparam logic [31:0]       H_RES_U  = 32'(H_RES);

    typedef enum logic [1:0] {
        IDLE,
        PAINT,
        CLEAR
    } state_t;

    state_t             state;
    logic               paint_pend;
    logic               clear_pend;
    logic [CW-1:0]      x0;
    logic [CW-1:0]      x_cur;
    logic [CW-1:0]      y_cur;
    logic [BW-1:0]      dx;
    logic [BW-1:0]      dy;
    logic [ADDR_W-1:0]  row_base;   // y_cur * H_RES, kept incrementally

    logic               origin_ok;
    logic [ADDR_W-1:0]  start_row;
    logic [ADDR_W-1:0]  start_addr;
    logic [CW-1:0]      x_next;
    logic [CW-1:0]      y_next;
    logic [ADDR_W-1:0]  next_base;
    logic               accept;
    logic               row_end;
    logic               last_px;

    always_comb begin
        origin_ok  = (cursor_x_pos < X_LIMIT) && (cursor_y_pos < Y_LIMIT);
        // One multiply per job start; every later address is an add.
        start_row  = ADDR_W'({21'd0, cursor_y_pos} * H_RES_U);
        start_addr = start_row + ADDR_W'(cursor_x_pos);

        // Wrap by compare-and-reset: coordinates only ever step by one.
        x_next    = (x_cur == X_LAST) ? '0 : x_cur + 1'b1;
        y_next    = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
        next_base = (y_cur == Y_LAST) ? '0 : row_base + ROW_STEP;

        accept  = fb_wr_en && fb_wr_ready;
        row_end = (dx == D_LAST);
        last_px = row_end && (dy == D_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            paint_pend <= 1'b0;
            clear_pend <= 1'b0;
            x0         <= '0;
            x_cur      <= '0;
            y_cur      <= '0;
            dx         <= '0;
            dy         <= '0;
            row_base   <= '0;
            fb_wr_en   <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            // Requests are captured here; the start branches below clear the
            // flag afterwards so a request landing on the start edge merges.
            if (paint_req) paint_pend <= 1'b1;
            if (clear_req) clear_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (clear_pend) begin
                        clear_pend <= 1'b0;
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        fb_wr_en   <= 1'b1;
                        fb_addr    <= '0;
                        fb_data    <= clear_color;
                    end else if (paint_pend) begin
                        paint_pend <= 1'b0;
                        state      <= PAINT;
                        busy       <= 1'b1;
                        x0         <= cursor_x_pos;
                        x_cur      <= cursor_x_pos;
                        y_cur      <= cursor_y_pos;
                        dx         <= '0;
                        dy         <= '0;
                        row_base   <= start_row;
                        fb_addr    <= start_addr;
                        fb_data    <= paint_color;
                        // Out-of-range origin: enter PAINT with no valid write
                        // so the job retires on the next edge.
                        fb_wr_en   <= origin_ok;
                    end
                end

                PAINT: begin
                    if (!fb_wr_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (accept) begin
                        if (last_px) begin
                            state    <= IDLE;
                            fb_wr_en <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (row_end) begin
                            dx       <= '0;
                            dy       <= dy + 1'b1;
                            x_cur    <= x0;
                            y_cur    <= y_next;
                            row_base <= next_base;
                            fb_addr  <= next_base + ADDR_W'(x0);
                        end else begin
                            dx      <= dx + 1'b1;
                            x_cur   <= x_next;
                            fb_addr <= row_base + ADDR_W'(x_next);
                        end
                    end
                end

                CLEAR: begin
                    if (accept) begin
                        if (fb_addr == A_LAST) begin
                            state    <= IDLE;
                            fb_wr_en <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            fb_addr <= fb_addr + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    fb_wr_en <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paint_scheduler.sv
// -----------------------------------------------------------------------------
// tb_paint_scheduler
//   Self-checking bench for paint_scheduler on a reduced 40x30 screen with a
//   4x4 brush so that full clears stay short. Accepted writes are captured by a
//   monitor and compared with a reference sequence built from the pixel rules.
// -----------------------------------------------------------------------------
module tb_paint_scheduler;

    localparam int H  = 40;
    localparam int V  = 30;
    localparam int B  = 4;
    localparam int CB = 3;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          paint_req = 1'b0;
    logic [10:0]   cursor_x_pos = '0;
    logic [10:0]   cursor_y_pos = '0;
    logic [CB-1:0] paint_color = '0;
    logic          clear_req = 1'b0;
    logic [CB-1:0] clear_color = '0;
    logic          fb_wr_en;
    logic [AW-1:0] fb_addr;
    logic [CB-1:0] fb_data;
    logic          fb_wr_ready = 1'b1;
    logic          busy;
    logic          done;

    paint_scheduler #(
        .H_RES  (H),
        .V_RES  (V),
        .BRUSH  (B),
        .COLOR_W(CB),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .paint_req   (paint_req),
        .cursor_x_pos(cursor_x_pos),
        .cursor_y_pos(cursor_y_pos),
        .paint_color (paint_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .fb_wr_en    (fb_wr_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_wr_ready (fb_wr_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int c;
        int n_wr;
        int first;
        int k;
        int k_addr;
        int last;
        int busy_cyc;
    } vec_t;

    wr_t got[$];
    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    int  busy_cnt = 0;
    int  ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Ready is changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       fb_wr_ready = 1'b1;
            1:       fb_wr_ready = ~fb_wr_ready;
            default: fb_wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: on the falling edge the values that the next rising edge will
    // see are stable.
    logic          p_stall = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [CB-1:0] p_data = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (p_stall) begin
                checks++;
                if (!fb_wr_en || fb_addr !== p_addr || fb_data !== p_data) begin
                    errors++;
                    $display("FAIL stall_hold: en=%0b addr=%0d data=%0d expected en=1 addr=%0d data=%0d",
                             fb_wr_en, fb_addr, fb_data, p_addr, p_data);
                end
            end
            if (fb_wr_en && fb_wr_ready) begin
                wr_t w;
                w.addr = fb_addr;
                w.data = fb_data;
                got.push_back(w);
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        p_stall = !reset && fb_wr_en && !fb_wr_ready;
        p_addr  = fb_addr;
        p_data  = fb_data;
    end

    // Reference model: the pixels a job must produce, in order.
    task automatic model_paint(input int x0, input int y0, input int c);
        if (x0 >= H || y0 >= V) return;
        for (int dy = 0; dy < B; dy++) begin
            for (int dx = 0; dx < B; dx++) begin
                wr_t w;
                w.addr = ((y0 + dy) % V) * H + ((x0 + dx) % H);
                w.data = c;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic model_clear(input int c);
        for (int a = 0; a < H * V; a++) begin
            wr_t w;
            w.addr = a;
            w.data = c;
            exp_q.push_back(w);
        end
    endtask

    task automatic compare_seq(input string name);
        int idx;
        idx = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (idx < 0 && (got[i].addr != exp_q[i].addr || got[i].data != exp_q[i].data))
                idx = i;
        checks++;
        if (got.size() != exp_q.size() || idx >= 0) begin
            errors++;
            if (idx >= 0)
                $display("FAIL %s: write %0d got addr=%0d data=%0d expected addr=%0d data=%0d",
                         name, idx, got[idx].addr, got[idx].data, exp_q[idx].addr, exp_q[idx].data);
            else
                $display("FAIL %s: got %0d writes expected %0d", name, got.size(), exp_q.size());
        end
    endtask

    task automatic clear_capture();
        got.delete();
        exp_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic req_paint(input int x, input int y, input int c);
        @(posedge clk); #1;
        cursor_x_pos = 11'(x);
        cursor_y_pos = 11'(y);
        paint_color  = CB'(c);
        paint_req    = 1'b1;
        @(posedge clk); #1;
        paint_req    = 1'b0;
    endtask

    task automatic req_clear(input int c);
        @(posedge clk); #1;
        clear_color = CB'(c);
        clear_req   = 1'b1;
        @(posedge clk); #1;
        clear_req   = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_finished"}, (done_cnt >= n) ? 1 : 0, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_progress"}, (got.size() >= n) ? 1 : 0, 1);
    endtask

    vec_t vecs[6];

    initial begin
        // {x, y, colour, writes, first, k, addr[k], last, busy cycles}
        vecs[0] = '{20, 15, 5, 16,  620,  4,  660,  743, 16};
        vecs[1] = '{38, 28, 3, 16, 1158,  2, 1120,   41, 16};
        vecs[2] = '{ 0,  0, 7, 16,    0, 15,  123,  123, 16};
        vecs[3] = '{39, 29, 1, 16, 1199,  1, 1160,   82, 16};
        vecs[4] = '{40,  0, 2,  0,    0,  0,    0,    0,  1};
        vecs[5] = '{ 0, 30, 4,  0,    0,  0,    0,    0,  1};

        // Reset state; a request held during reset must not survive it.
        paint_req = 1'b1;
        clear_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_en", fb_wr_en, 0);
        check("rst_addr",  fb_addr,  0);
        check("rst_data",  fb_data,  0);
        check("rst_busy",  busy,     0);
        check("rst_done",  done,     0);
        paint_req = 1'b0;
        clear_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_capture();
        repeat (6) @(posedge clk);
        check("post_reset_no_writes", got.size(), 0);
        check("post_reset_no_done",   done_cnt,   0);

        // Request-to-first-write latency.
        clear_capture();
        @(posedge clk); #1;
        cursor_x_pos = 11'd0;
        cursor_y_pos = 11'd0;
        paint_color  = 3'd6;
        paint_req    = 1'b1;
        @(posedge clk); #1;        // request sampled at this edge
        paint_req    = 1'b0;
        @(negedge clk);
        check("lat_pend_wr_en", fb_wr_en, 0);
        check("lat_pend_busy",  busy,     0);
        @(negedge clk);            // after the start edge
        check("lat_start_wr_en", fb_wr_en, 1);
        check("lat_start_busy",  busy,     1);
        check("lat_start_addr",  fb_addr,  0);
        model_paint(0, 0, 6);
        wait_done(1, 200, "lat");
        compare_seq("lat_seq");

        // Table-driven paints with an always-ready framebuffer.
        for (int i = 0; i < 6; i++) begin
            clear_capture();
            req_paint(vecs[i].x, vecs[i].y, vecs[i].c);
            model_paint(vecs[i].x, vecs[i].y, vecs[i].c);
            wait_done(1, 200, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_count", i), got.size(), vecs[i].n_wr);
            check($sformatf("tbl%0d_done", i),  done_cnt,   1);
            check($sformatf("tbl%0d_busy", i),  busy_cnt,   vecs[i].busy_cyc);
            if (vecs[i].n_wr > 0 && got.size() == vecs[i].n_wr) begin
                check($sformatf("tbl%0d_first", i), got[0].addr, vecs[i].first);
                check($sformatf("tbl%0d_kth", i),   got[vecs[i].k].addr, vecs[i].k_addr);
                check($sformatf("tbl%0d_last", i),  got[vecs[i].n_wr-1].addr, vecs[i].last);
            end
            compare_seq($sformatf("tbl%0d_seq", i));
        end

        // Backpressure: ready toggles every cycle.
        ready_mode = 1;
        clear_capture();
        req_paint(20, 15, 5);
        model_paint(20, 15, 5);
        wait_done(1, 400, "bp");
        compare_seq("bp_seq");
        check("bp_done", done_cnt, 1);
        ready_mode = 0;

        // Simultaneous requests: clear first, paint origin sampled at its own start.
        clear_capture();
        @(posedge clk); #1;
        clear_color  = 3'd0;
        cursor_x_pos = 11'd5;
        cursor_y_pos = 11'd5;
        paint_color  = 3'd6;
        clear_req    = 1'b1;
        paint_req    = 1'b1;
        @(posedge clk); #1;
        clear_req    = 1'b0;
        paint_req    = 1'b0;
        cursor_x_pos = 11'd10;
        cursor_y_pos = 11'd12;
        model_clear(0);
        model_paint(10, 12, 6);
        wait_done(2, 4000, "arb");
        compare_seq("arb_seq");
        check("arb_done", done_cnt, 2);

        // Clear requested twice during a paint: paint completes, one clear follows.
        clear_capture();
        req_paint(30, 20, 4);
        wait_writes(3, 100, "mid");
        @(posedge clk); #1;
        clear_color = 3'd5;
        clear_req   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear_req   = 1'b0;
        model_paint(30, 20, 4);
        model_clear(5);
        wait_done(2, 4000, "mid");
        compare_seq("mid_seq");
        check("mid_done", done_cnt, 2);

        // Asynchronous reset in the middle of a paint.
        begin
            int n_at;
            clear_capture();
            req_paint(20, 15, 2);
            wait_writes(6, 100, "rstjob");
            #3;
            reset = 1'b1;
            #1;
            check("rstjob_wr_en", fb_wr_en, 0);
            check("rstjob_busy",  busy,     0);
            n_at = got.size();
            @(posedge clk); #1;
            reset = 1'b0;
            repeat (10) @(posedge clk);
            check("rstjob_no_writes", got.size(), n_at);
            check("rstjob_no_done",   done_cnt,   0);
            clear_capture();
            req_paint(20, 15, 2);
            model_paint(20, 15, 2);
            wait_done(1, 200, "rstjob_fresh");
            compare_seq("rstjob_fresh_seq");
        end

        // Randomised jobs against the reference model under random ready.
        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            int rx, ry, rc;
            clear_capture();
            rc = int'($urandom_range(0, (1 << CB) - 1));
            if (i % 4 == 3) begin
                req_clear(rc);
                model_clear(rc);
            end else begin
                rx = int'($urandom_range(0, H + 2));
                ry = int'($urandom_range(0, V + 2));
                req_paint(rx, ry, rc);
                model_paint(rx, ry, rc);
            end
            wait_done(1, 8000, $sformatf("rnd%0d", i));
            compare_seq($sformatf("rnd%0d_seq", i));
            check($sformatf("rnd%0d_done", i), done_cnt, 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
